td4_run_ctrl: RTL and testbench



---
 rtl/td4_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_td4_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: CPU clock-enable generation (step/slow/fast), program
// loading over valid/ready with the core held in reset, and PC breakpoint halt.
module td4_run_ctrl #(
   parameter int unsigned DIV_SLOW = 1000,
   parameter int unsigned DIV_FAST = 100,
   parameter int unsigned DEBOUNCE = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [1:0] MODE,
   input  logic       STEP_BTN,
   input  logic       CONT,
   input  logic       LOAD_REQ,
   input  logic       LOAD_VALID,
   input  logic [3:0] LOAD_ADDR,
   input  logic [7:0] LOAD_DATA,
   output logic       LOAD_READY,
   output logic       ROM_WE,
   output logic [3:0] ROM_ADDR,
   output logic [7:0] ROM_WDATA,
   input  logic [3:0] PC,
   input  logic       BREAK_EN,
   input  logic [3:0] BREAK_ADDR,
   output logic       CPU_EN,
   output logic       CPU_RESET_N,
   output logic [1:0] STATE
);

   localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int unsigned DIV_W   = $clog2(DIV_MAX);
   localparam int unsigned DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_RUN   = 2'b10,
      ST_BREAK = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic              hold_cnt_q, hold_cnt_d;
   logic              cpu_en_q, cpu_en_d;
   logic              cpu_reset_n_q, cpu_reset_n_d;
   logic              load_ready_q, load_ready_d;
   logic              rom_we_q, rom_we_d;
   logic [3:0]        rom_addr_q, rom_addr_d;
   logic [7:0]        rom_wdata_q, rom_wdata_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        mode_q, mode_d;
   logic              en_seen_q, en_seen_d;
   logic [1:0]        sync_q, sync_d;
   logic              db_q, db_d;
   logic              db_prev_q, db_prev_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;

   logic              xfer_c;
   logic              brk_hit_c;
   logic              mode_chg_c;
   logic [DIV_W-1:0]  div_top_c;
   logic [DIV_W-1:0]  div_eff_c;
   logic              div_hit_c;
   logic              press_c;

   // A mode change makes the current cycle count as divider phase 0.
   assign xfer_c     = (state_q == ST_LOAD) & LOAD_VALID & load_ready_q;
   assign brk_hit_c  = en_seen_q & BREAK_EN & (PC == BREAK_ADDR);
   assign mode_chg_c = (MODE != mode_q);
   assign div_top_c  = (MODE == 2'b10) ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1);
   assign div_eff_c  = mode_chg_c ? '0 : div_q;
   assign div_hit_c  = MODE[1] & (div_eff_c == div_top_c);
   assign press_c    = (MODE == 2'b01) & db_q & ~db_prev_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_HOLD;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD:  if (hold_cnt_q) state_d = LOAD_REQ ? ST_LOAD : ST_RUN;
         ST_LOAD:  if (!LOAD_REQ && !xfer_c) state_d = ST_HOLD;
         ST_RUN: begin
            if (LOAD_REQ)       state_d = ST_LOAD;
            else if (brk_hit_c) state_d = ST_BREAK;
         end
         default: begin
            if (LOAD_REQ)  state_d = ST_LOAD;
            else if (CONT) state_d = ST_RUN;
         end
      endcase
   end

   always_comb begin
      hold_cnt_d    = 1'b0;
      cpu_en_d      = 1'b0;
      div_d         = '0;
      cpu_reset_n_d = (state_d == ST_RUN) || (state_d == ST_BREAK);
      rom_we_d      = xfer_c;
      rom_addr_d    = xfer_c ? LOAD_ADDR : rom_addr_q;
      rom_wdata_d   = xfer_c ? LOAD_DATA : rom_wdata_q;
      load_ready_d  = (state_d == ST_LOAD) && !xfer_c;
      mode_d        = MODE;
      en_seen_d     = cpu_en_q;
      sync_d        = {sync_q[0], STEP_BTN};
      db_prev_d     = db_q;
      db_d          = db_q;
      db_cnt_d      = '0;

      case (state_q)
         ST_HOLD: hold_cnt_d = ~hold_cnt_q;
         ST_RUN: begin
            if (state_d == ST_RUN) begin
               cpu_en_d = (div_hit_c | press_c) & ~cpu_en_q;
               div_d    = (!MODE[1] || div_hit_c) ? '0 : div_eff_c + DIV_W'(1);
            end
         end
         ST_BREAK: if (state_d == ST_RUN) cpu_en_d = 1'b1;
         default: ;
      endcase

      // Debounce: accept a new level after DEBOUNCE consecutive differing samples.
      if (sync_q[1] != db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE - 1)) db_d = sync_q[1];
         else                                 db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hold_cnt_q    <= 1'b0;
         cpu_en_q      <= 1'b0;
         cpu_reset_n_q <= 1'b0;
         load_ready_q  <= 1'b0;
         rom_we_q      <= 1'b0;
         rom_addr_q    <= '0;
         rom_wdata_q   <= '0;
         div_q         <= '0;
         mode_q        <= '0;
         en_seen_q     <= 1'b0;
         sync_q        <= '0;
         db_q          <= 1'b0;
         db_prev_q     <= 1'b0;
         db_cnt_q      <= '0;
      end else begin
         hold_cnt_q    <= hold_cnt_d;
         cpu_en_q      <= cpu_en_d;
         cpu_reset_n_q <= cpu_reset_n_d;
         load_ready_q  <= load_ready_d;
         rom_we_q      <= rom_we_d;
         rom_addr_q    <= rom_addr_d;
         rom_wdata_q   <= rom_wdata_d;
         div_q         <= div_d;
         mode_q        <= mode_d;
         en_seen_q     <= en_seen_d;
         sync_q        <= sync_d;
         db_q          <= db_d;
         db_prev_q     <= db_prev_d;
         db_cnt_q      <= db_cnt_d;
      end
   end

   assign STATE       = state_q;
   assign CPU_EN      = cpu_en_q;
   assign CPU_RESET_N = cpu_reset_n_q;
   assign LOAD_READY  = load_ready_q;
   assign ROM_WE      = rom_we_q;
   assign ROM_ADDR    = rom_addr_q;
   assign ROM_WDATA   = rom_wdata_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: directed scenarios plus randomized mode/button
// segments checked against pulse timing derived from the run-mode rules.
module tb_td4_run_ctrl;

   localparam int unsigned DIV_SLOW = 6;
   localparam int unsigned DIV_FAST = 4;
   localparam int unsigned DEBOUNCE = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       step_btn = 1'b0;
   logic       cont = 1'b0;
   logic       load_req = 1'b0;
   logic       load_valid = 1'b0;
   logic [3:0] load_addr = 4'd0;
   logic [7:0] load_data = 8'd0;
   logic       load_ready;
   logic       rom_we;
   logic [3:0] rom_addr;
   logic [7:0] rom_wdata;
   logic [3:0] pc = 4'd0;
   logic       break_en = 1'b0;
   logic [3:0] break_addr = 4'd0;
   logic       cpu_en;
   logic       cpu_reset_n;
   logic [1:0] state;

   int cyc = 0;
   int total = 0;
   int passed = 0;
   int failed = 0;

   td4_run_ctrl #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST), .DEBOUNCE(DEBOUNCE)) dut (
      .CLK(clk), .RESET_N(rst_n), .MODE(mode), .STEP_BTN(step_btn), .CONT(cont),
      .LOAD_REQ(load_req), .LOAD_VALID(load_valid), .LOAD_ADDR(load_addr),
      .LOAD_DATA(load_data), .LOAD_READY(load_ready), .ROM_WE(rom_we),
      .ROM_ADDR(rom_addr), .ROM_WDATA(rom_wdata), .PC(pc), .BREAK_EN(break_en),
      .BREAK_ADDR(break_addr), .CPU_EN(cpu_en), .CPU_RESET_N(cpu_reset_n), .STATE(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock; the bench plays the TD4 PC register (cleared by CPU_RESET_N, bumped by CPU_EN).
   task automatic step();
      logic en, rn;
      en = cpu_en;
      rn = cpu_reset_n;
      @(posedge clk);
      #1;
      cyc++;
      if (!rn)     pc = 4'd0;
      else if (en) pc = pc + 4'd1;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_rstn"},  32'(cpu_reset_n), 32'd0);
      chk({tag, "_en"},    32'(cpu_en), 32'd0);
      chk({tag, "_rdy"},   32'(load_ready), 32'd0);
      chk({tag, "_we"},    32'(rom_we), 32'd0);
      chk({tag, "_addr"},  32'(rom_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(rom_wdata), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int base, k, nw, nwe, h, seg_len, div;
      logic xfer;
      logic [1:0] cur, nm;

      // Reset and fast run
      mode = 2'b11;
      do_reset();
      rst_chk("rst0");
      for (int c = 1; c <= 16; c++) begin
         step();
         chk("fast_en", 32'(cpu_en), 32'(c >= 6 && (c - 2) % 4 == 0));
         chk("fast_rstn", 32'(cpu_reset_n), 32'(c >= 2));
      end

      // Program load: 16 words streamed with valid held high
      load_req = 1'b1;
      step();
      chk("ld_state", 32'(state), 32'd1);
      chk("ld_rstn", 32'(cpu_reset_n), 32'd0);
      chk("ld_en", 32'(cpu_en), 32'd0);
      nw = 0; nwe = 0;
      load_valid = 1'b1; load_addr = 4'd0; load_data = 8'hB0;
      for (int i = 0; i < 40 && nwe < 16; i++) begin
         xfer = load_valid && load_ready;
         step();
         chk("ld_we", 32'(rom_we), 32'(xfer));
         chk("ld_rdy", 32'(load_ready), 32'(!xfer));
         chk("ld_cpu_en", 32'(cpu_en), 32'd0);
         if (rom_we) begin
            chk("ld_addr", 32'(rom_addr), 32'(nwe));
            chk("ld_data", 32'(rom_wdata), 32'(8'hB0 + nwe));
            nwe++;
         end
         if (xfer) begin
            nw++;
            if (nw < 16) begin
               load_addr = 4'(nw);
               load_data = 8'(8'hB0 + nw);
            end else begin
               load_valid = 1'b0;
            end
         end
      end
      chk("ld_count", 32'(nwe), 32'd16);
      load_req = 1'b0;
      step();
      chk("hold1_state", 32'(state), 32'd0);
      chk("hold1_rstn", 32'(cpu_reset_n), 32'd0);
      step();
      chk("hold2_state", 32'(state), 32'd0);
      step();
      chk("run_state", 32'(state), 32'd2);
      chk("run_rstn", 32'(cpu_reset_n), 32'd1);

      // Manual step: 10-cycle glitch, then a 40-cycle press
      mode = 2'b01;
      step_btn = 1'b1;
      for (int j = 1; j <= 50; j++) begin
         step();
         if (j == 10) step_btn = 1'b0;
         chk("glitch_en", 32'(cpu_en), 32'd0);
      end
      step_btn = 1'b1;
      for (int j = 1; j <= 70; j++) begin
         step();
         if (j == 40) step_btn = 1'b0;
         chk("press_en", 32'(cpu_en), 32'(j == 19));
      end

      // Breakpoint at PC 3 in fast run from PC 0, then CONT
      mode = 2'b11; break_en = 1'b1; break_addr = 4'd3; load_req = 1'b1;
      step();
      load_req = 1'b0;
      repeat (3) step();
      chk("brk_run", 32'(state), 32'd2);
      chk("brk_pc0", 32'(pc), 32'd0);
      for (int j = 1; j <= 20; j++) begin
         step();
         chk("brk_en", 32'(cpu_en), 32'(j == 4 || j == 8 || j == 12));
         chk("brk_state", 32'(state), (j >= 14) ? 32'd3 : 32'd2);
         if (j == 14) chk("brk_pc", 32'(pc), 32'd3);
      end
      cont = 1'b1;
      step();
      cont = 1'b0;
      chk("cont_en", 32'(cpu_en), 32'd1);
      chk("cont_state", 32'(state), 32'd2);
      for (int j = 2; j <= 10; j++) begin
         step();
         chk("resume_en", 32'(cpu_en), 32'(j == 5 || j == 9));
      end

      // LOAD_REQ and breakpoint match in the same cycle
      break_addr = pc;
      load_req = 1'b1;
      step();
      chk("prio_state", 32'(state), 32'd1);
      chk("prio_rstn", 32'(cpu_reset_n), 32'd0);
      chk("prio_en", 32'(cpu_en), 32'd0);
      chk("prio_rdy", 32'(load_ready), 32'd1);

      // Reset asserted in a transfer cycle drops the write
      load_valid = 1'b1; load_addr = 4'd5; load_data = 8'h55;
      rst_n = 1'b0;
      #1;
      rst_chk("arst");
      step();
      rst_chk("arst1");
      step();
      rst_chk("arst2");
      rst_n = 1'b1; load_req = 1'b0; load_valid = 1'b0; break_en = 1'b0;
      cyc = 0;
      step();
      chk("arst_we", 32'(rom_we), 32'd0);
      chk("arst_hold", 32'(state), 32'd0);

      // Randomized mode segments and button activity
      mode = 2'b00;
      do_reset();
      repeat (3) step();
      cur = 2'b00;
      for (int s = 0; s < 8; s++) begin
         nm = 2'($urandom_range(0, 3));
         while (nm == cur) nm = 2'($urandom_range(0, 3));
         cur = nm;
         mode = nm;
         if (nm == 2'b01) begin
            for (int e = 0; e < 3; e++) begin
               h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16, 40))
                                                : int'($urandom_range(1, 15));
               step_btn = 1'b1;
               for (int j = 1; j <= h + 25; j++) begin
                  step();
                  if (j == h) step_btn = 1'b0;
                  chk("rnd_man_en", 32'(cpu_en), 32'(h >= 16 && j == 19));
               end
            end
         end else begin
            seg_len = int'($urandom_range(8, 30));
            div = (nm == 2'b10) ? int'(DIV_SLOW) : int'(DIV_FAST);
            for (int j = 1; j <= seg_len; j++) begin
               step();
               chk("rnd_div_en", 32'(cpu_en), 32'(nm[1] && (j % div) == 0));
            end
         end
      end
      chk("rnd_state", 32'(state), 32'd2);

      base = 0; k = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
